// File: rtl/div3_pkg.sv
// div3_pkg: shared state encoding, default width and counter-width helper for the div3 serializer
package div3_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} ser_state_t;

  localparam int DIV3_DEFAULT_WIDTH = 8;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div3_serializer.sv
// div3_serializer: parallel-to-serial MSB-first feeder with restart pulse for the div-by-3 checker
// Optional DIV3_SER_STALL_EN adds a stall input that freezes shifting in SHIFT.
module div3_serializer
  import div3_pkg::*;
#(
  parameter int WIDTH = DIV3_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_clr,
  output logic             ser_last,
`ifdef DIV3_SER_STALL_EN
  input  logic             stall,
`endif
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);

`ifndef DIV3_SER_STALL_EN
  logic stall;
  assign stall = 1'b0;
`endif

  ser_state_t state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0] cnt, cnt_n;
  logic accept;

  // ser_last is only ever high in SHIFT, so it doubles as the back-to-back accept window
  always_comb begin
    state_n = state;
    sreg_n = sreg;
    cnt_n = cnt;
    in_ready = !reset && !stall && (state == IDLE || ser_last);
    accept = in_valid && in_ready;
    if (accept) begin
      state_n = CLEAR;
      sreg_n = in_data;
      cnt_n = CW'(WIDTH - 1);
    end else if (state == CLEAR) begin
      state_n = SHIFT;
    end else if (state == SHIFT && !stall) begin
      state_n = ser_last ? IDLE : SHIFT;
      sreg_n = {sreg[WIDTH-2:0], 1'b0};
      cnt_n = ser_last ? cnt : cnt - 1'b1;
    end
  end

  // outputs are registered from the next-state values so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg <= '0;
      cnt <= '0;
      ser_bit <= 1'b0;
      ser_valid <= 1'b0;
      ser_clr <= 1'b0;
      ser_last <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      sreg <= sreg_n;
      cnt <= cnt_n;
      ser_bit <= state_n == SHIFT && sreg_n[WIDTH-1];
      ser_valid <= state_n == SHIFT;
      ser_clr <= state_n == CLEAR;
      ser_last <= state_n == SHIFT && cnt_n == '0;
      busy <= state_n != IDLE;
    end
  end

endmodule

// File: tb/tb_div3_serializer.sv
// tb_div3_serializer: directed, table-driven and randomized checks of div3_serializer (WIDTH 8 and 2)
module tb_div3_serializer;

  logic clk = 1'b0;
  logic reset, in_valid, stall;
  logic [7:0] in_data;
  logic in_ready, ser_bit, ser_valid, ser_clr, ser_last, busy;
  logic v2;
  logic [1:0] d2;
  logic rdy2, b2, vl2, c2, l2, bz2;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] d;
    logic div3;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  div3_serializer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_clr(ser_clr), .ser_last(ser_last),
`ifdef DIV3_SER_STALL_EN
    .stall(stall),
`endif
    .busy(busy)
  );

  div3_serializer #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .ser_bit(b2), .ser_valid(vl2), .ser_clr(c2), .ser_last(l2),
`ifdef DIV3_SER_STALL_EN
    .stall(1'b0),
`endif
    .busy(bz2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    check(name, {busy, ser_valid, ser_clr, ser_last, in_ready}, 5'b00001);
  endtask

  // Entered just after a negedge with word d presented; checks the full CLEAR+SHIFT frame.
  task automatic run_word(input logic [7:0] d, input logic exp_div3, input logic nv,
                          input logic [7:0] nd, input logic junk);
    int val = 0;
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = junk;
    in_data = junk ? 8'hFF : ~d;
    @(negedge clk);
    check("clr_cycle", {ser_clr, ser_valid, busy, in_ready}, 4'b1010);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("shift_bit", {ser_valid, ser_clr, ser_bit, ser_last, in_ready, busy},
            {1'b1, 1'b0, d[7-i], i == 7, i == 7, 1'b1});
      val = val * 2 + int'(ser_bit);
      if (i == 7) begin
        in_valid = nv;
        in_data = nd;
      end
    end
    check("verdict", val % 3 == 0, exp_div3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] cur, nxt;
    logic b2b, last;
    int val, cyc, clr_at;
    vecs[0] = '{8'h03, 1'b1};
    vecs[1] = '{8'h00, 1'b1};
    vecs[2] = '{8'hFF, 1'b1};
    vecs[3] = '{8'h80, 1'b0};
    vecs[4] = '{8'h55, 1'b0};
    vecs[5] = '{8'hA5, 1'b1};
    vecs[6] = '{8'h01, 1'b0};
    vecs[7] = '{8'h7E, 1'b1};
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    stall = 1'b0;
    v2 = 1'b0;
    d2 = '0;
    @(negedge clk);
    in_valid = 1'b1;
    v2 = 1'b1;
    check("reset_outs", {ser_bit, ser_valid, ser_clr, ser_last, busy, in_ready}, 6'b0);
    check("reset_outs_w2", {b2, vl2, c2, l2, bz2, rdy2}, 6'b0);
    @(negedge clk);
    in_valid = 1'b0;
    v2 = 1'b0;
    reset = 1'b0;
    idle_check("idle_after_reset");
    // single word 0x03
    in_valid = 1'b1;
    in_data = 8'h03;
    run_word(8'h03, 1'b1, 1'b0, 8'h00, 1'b0);
    idle_check("idle_after_03");
    // back-to-back 0x06 then 0x07
    in_valid = 1'b1;
    in_data = 8'h06;
    run_word(8'h06, 1'b1, 1'b1, 8'h07, 1'b0);
    run_word(8'h07, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_check("idle_after_b2b");
    // 0xFF offered while busy must be ignored
    in_valid = 1'b1;
    in_data = 8'h09;
    run_word(8'h09, 1'b1, 1'b0, 8'h00, 1'b1);
    idle_check("ff_not_accepted");
    // reset on the 4th bit of 0xA5
    in_valid = 1'b1;
    in_data = 8'hA5;
    check("a5_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("a5_clr", ser_clr, 1);
    cur = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("a5_bit", {ser_valid, ser_bit, ser_last}, {1'b1, cur[7-i], 1'b0});
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_outs", {ser_bit, ser_valid, ser_clr, ser_last, busy, in_ready}, 6'b0);
    reset = 1'b0;
    idle_check("idle_after_abort");
    in_valid = 1'b1;
    in_data = 8'h0C;
    run_word(8'h0C, 1'b1, 1'b0, 8'h00, 1'b0);
    idle_check("idle_after_0c");
    // table: all vectors back-to-back
    in_valid = 1'b1;
    in_data = vecs[0].d;
    for (int k = 0; k < 8; k++)
      run_word(vecs[k].d, vecs[k].div3, k < 7, k < 7 ? vecs[(k + 1) % 8].d : 8'h00, 1'b0);
    idle_check("idle_after_table");
    // randomized words, gaps and junk offers; expected verdict from plain arithmetic
    cur = 8'($urandom);
    in_valid = 1'b1;
    in_data = cur;
    for (int r = 0; r < 30; r++) begin
      last = r == 29;
      nxt = 8'($urandom);
      b2b = last ? 1'b0 : 1'($urandom_range(0, 1));
      run_word(cur, cur % 3 == 0, b2b, nxt, $urandom_range(0, 3) == 0);
      if (!b2b && !last) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        in_valid = 1'b1;
        in_data = nxt;
      end
      cur = nxt;
    end
    idle_check("idle_after_random");
`ifdef DIV3_SER_STALL_EN
    // stall for 3 cycles while bit 5 of 0x12 is on the line
    cur = 8'h12;
    in_valid = 1'b1;
    in_data = cur;
    check("stall_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("stall_clr", ser_clr, 1);
    cyc = 0;
    val = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cyc++;
      check("stall_bit", {ser_valid, ser_bit, ser_last}, {1'b1, cur[7-i], i == 7});
      val = val * 2 + int'(ser_bit);
      if (i == 4) begin
        stall = 1'b1;
        for (int h = 0; h < 3; h++) begin
          @(negedge clk);
          cyc++;
          check("stall_hold", {ser_valid, ser_bit, ser_last, in_ready}, {1'b1, cur[3], 1'b0, 1'b0});
        end
        stall = 1'b0;
      end
    end
    check("stall_word", val, 32'h12);
    check("stall_shift_cycles", cyc, 11);
    idle_check("idle_after_stall");
`endif
    // WIDTH=2: 2'b11 then 2'b10 back-to-back
    v2 = 1'b1;
    d2 = 2'b11;
    check("w2_ready", rdy2, 1);
    @(posedge clk);
    #1;
    d2 = 2'b10;
    cyc = 0;
    clr_at = 0;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      cyc++;
      check("w2_clr", {c2, vl2, bz2}, 3'b101);
      if (w == 1) check("w2_period", cyc - clr_at, 3);
      clr_at = cyc;
      val = 0;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        cyc++;
        check("w2_bit", {vl2, b2, l2, rdy2}, {1'b1, (w == 0) ? 1'b1 : (i == 0), i == 1, i == 1});
        val = val * 2 + int'(b2);
        if (w == 1 && i == 1) v2 = 1'b0;
      end
      check("w2_verdict", val % 3 == 0, w == 0);
    end
    @(negedge clk);
    check("w2_idle", {bz2, vl2, rdy2}, 3'b001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
